conv_frame_encoder: RTL and testbench

// - Transmit-side counterpart of the Viterbi decoder in endec: encodes a MSG_LEN-bit message with a

---
 rtl/conv_frame_encoder.sv | 147 ++++++++++++++
 tb/tb_conv_frame_encoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_encoder.sv
// Convolutional frame encoder (R=1/2 or 1/3, K=3..9) with zero tail, packed frame output.
// Optional symbol stream port is enabled by defining ENDEC_SYM_STREAM_EN.
module conv_frame_encoder #(
  parameter int MSG_LEN = 128,
  parameter int MAX_K   = 9,
  parameter int MAX_R   = 3,
  parameter int FRAME_W = (MSG_LEN + MAX_K - 1) * MAX_R,
  parameter int LEN_W   = $clog2(FRAME_W + 1)
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               i_start,
  input  logic               i_code_rate,
  input  logic [1:0]         i_constr_len,
  input  logic [MAX_K-1:0]   i_gen_poly [MAX_R],
  input  logic [MSG_LEN-1:0] i_msg,
  output logic               o_busy,
  output logic               o_done,
  output logic [FRAME_W-1:0] o_frame,
  output logic [LEN_W-1:0]   o_frame_len
`ifdef ENDEC_SYM_STREAM_EN
  ,
  output logic [MAX_R-1:0]   o_sym,
  output logic               o_sym_valid
`endif
);

  localparam int CNT_W = $clog2(MSG_LEN + MAX_K);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    TAIL
  } state_t;

  state_t state_q, state_d;

  logic [MSG_LEN-1:0] msg_q;
  logic               rate_q;
  logic [1:0]         k_q;
  logic [MAX_K-1:0]   poly_q [MAX_R];
  logic [MAX_K-1:1]   sreg_q;
  logic [CNT_W-1:0]   t_q;

  logic [3:0]         kval;
  logic [3:0]         kin;
  logic [MAX_K-1:0]   kmask;
  logic [MAX_K-1:0]   s;
  logic [MAX_R-1:0]   sym;
  logic [LEN_W-1:0]   pos;
  logic [LEN_W-1:0]   tot;
  logic [LEN_W-1:0]   len_in;
  logic [FRAME_W-1:0] sym_wide;
  logic [CNT_W-1:0]   last_t;
  logic               last;

  always_comb begin
    kval   = {1'b0, k_q, 1'b1} + 4'd2;
    kin    = {1'b0, i_constr_len, 1'b1} + 4'd2;
    kmask  = ~({MAX_K{1'b1}} << kval);
    s      = {sreg_q, msg_q[MSG_LEN-1]};
    last_t = CNT_W'(MSG_LEN - 2) + CNT_W'(kval);
    last   = (state_q == TAIL) && (t_q == last_t);
    tot    = LEN_W'(MSG_LEN - 1) + LEN_W'(kin);
    len_in = tot + tot + (i_code_rate ? tot : '0);
    pos    = LEN_W'(t_q) + LEN_W'(t_q) + (rate_q ? LEN_W'(t_q) : '0);
  end

  // Output 0 lands in the symbol MSB; output 2 exists only at rate 1/3.
  always_comb begin
    sym = '0;
    for (int j = 0; j < MAX_R; j++) begin
      sym[MAX_R-1-j] = ((j < 2) || rate_q) & (^(poly_q[j] & kmask & s));
    end
    sym_wide = {sym, {(FRAME_W-MAX_R){1'b0}}} >> pos;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (i_start) state_d = ENCODE;
      ENCODE: if (t_q == CNT_W'(MSG_LEN - 1)) state_d = TAIL;
      TAIL:   if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The message register shifts out MSB-first with zero fill, so the tail
  // phase needs no separate input path.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      msg_q       <= '0;
      rate_q      <= 1'b0;
      k_q         <= '0;
      for (int j = 0; j < MAX_R; j++) poly_q[j] <= '0;
      sreg_q      <= '0;
      t_q         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_frame     <= '0;
      o_frame_len <= '0;
    end else if (en) begin
      o_done <= 1'b0;
      if (state_q == IDLE) begin
        if (i_start) begin
          msg_q       <= i_msg;
          rate_q      <= i_code_rate;
          k_q         <= i_constr_len;
          poly_q      <= i_gen_poly;
          sreg_q      <= '0;
          t_q         <= '0;
          o_busy      <= 1'b1;
          o_frame     <= '0;
          o_frame_len <= len_in;
        end
      end else begin
        msg_q   <= msg_q << 1;
        sreg_q  <= s[MAX_K-2:0];
        t_q     <= t_q + 1'b1;
        o_frame <= o_frame | sym_wide;
        if (last) begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
      end
    end
  end

`ifdef ENDEC_SYM_STREAM_EN
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      o_sym       <= '0;
      o_sym_valid <= 1'b0;
    end else if (en) begin
      o_sym_valid <= (state_q != IDLE);
      o_sym       <= (state_q != IDLE) ? sym : '0;
    end
  end
`endif

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed bench for conv_frame_encoder: impulse, zero, stall, reset and busy-start cases.
module tb_conv_frame_encoder;

  localparam int FW = 408;
  localparam int LW = 9;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          i_start = 1'b0;
  logic          i_code_rate = 1'b0;
  logic [1:0]    i_constr_len = '0;
  logic [8:0]    poly [3];
  logic [127:0]  i_msg = '0;
  logic          o_busy;
  logic          o_done;
  logic [FW-1:0] o_frame;
  logic [LW-1:0] o_frame_len;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;
  int nd;
  logic [FW-1:0] e;

  conv_frame_encoder dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .en          (en),
    .i_start     (i_start),
    .i_code_rate (i_code_rate),
    .i_constr_len(i_constr_len),
    .i_gen_poly  (poly),
    .i_msg       (i_msg),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_frame     (o_frame),
    .o_frame_len (o_frame_len)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [FW-1:0] got,
                     input logic [FW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] imp_exp(input logic [8:0] p0,
    input logic [8:0] p1, input logic [8:0] p2, input int k, input bit r3);
    logic [FW-1:0] v;
    int w;
    v = '0;
    w = r3 ? 3 : 2;
    for (int t = 0; t < k; t++) begin
      v[FW-1-t*w] = p0[t];
      v[FW-2-t*w] = p1[t];
      if (r3) v[FW-3-t*w] = p2[t];
    end
    return v;
  endfunction

  task automatic start_frame();
    @(negedge sys_clk);
    i_start = 1'b1;
    @(negedge sys_clk);
    i_start = 1'b0;
  endtask

  task automatic run(input int gap_at, input int gap_len, input int pulse_at,
                     input int limit, output int l, output int n);
    l = -1;
    n = 0;
    for (int c = 1; c <= limit; c++) begin
      if (c - 1 == gap_at) en = 1'b0;
      if (c - 1 == gap_at + gap_len) en = 1'b1;
      i_start = (c - 1 == pulse_at);
      if (c - 1 == pulse_at) begin
        i_msg = '1;
        i_code_rate = 1'b0;
        i_constr_len = 2'd0;
        poly[0] = '0;
      end
      @(negedge sys_clk);
      if (o_done) begin
        n++;
        if (l < 0) l = c;
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    poly[0] = 9'b101_010_111;
    poly[1] = 9'b110_000_101;
    poly[2] = 9'h1ff;

    @(negedge sys_clk);
    chk("rst_busy", FW'(o_busy), '0);
    chk("rst_done", FW'(o_done), '0);
    chk("rst_frame", o_frame, '0);
    chk("rst_len", FW'(o_frame_len), '0);
    rst = 1'b1;

    i_msg = 128'd1 << 127;
    start_frame();
    chk("k3_busy", FW'(o_busy), FW'(1));
    chk("k3_len", FW'(o_frame_len), FW'(260));
    run(-1, 0, -1, 160, lat, nd);
    e = '0;
    e[FW-1 -: 6] = 6'b111011;
    chk("k3_frame", o_frame, e);
    chk("k3_lat", FW'(lat), FW'(130));
    chk("k3_ndone", FW'(nd), FW'(1));
    chk("k3_busy_end", FW'(o_busy), '0);

    poly[0] = 9'b111101101;
    poly[1] = 9'b110011011;
    poly[2] = 9'b100100111;
    i_code_rate = 1'b1;
    i_constr_len = 2'd3;
    i_msg = 128'd1 << 127;
    start_frame();
    chk("k9_len", FW'(o_frame_len), FW'(408));
    run(-1, 0, 10, 170, lat, nd);
    e = imp_exp(9'b111101101, 9'b110011011, 9'b100100111, 9, 1'b1);
    chk("k9_frame", o_frame, e);
    chk("k9_lat", FW'(lat), FW'(136));
    chk("k9_ndone", FW'(nd), FW'(1));

    i_msg = '0;
    i_code_rate = 1'b1;
    i_constr_len = 2'd1;
    poly[0] = 9'h1ff;
    poly[1] = 9'h0f5;
    poly[2] = 9'h013;
    start_frame();
    chk("zero_len", FW'(o_frame_len), FW'(396));
    run(-1, 0, -1, 160, lat, nd);
    chk("zero_frame", o_frame, '0);
    chk("zero_lat", FW'(lat), FW'(132));
    chk("zero_ndone", FW'(nd), FW'(1));

    poly[0] = 9'b000_000_111;
    poly[1] = 9'b000_000_101;
    i_code_rate = 1'b0;
    i_constr_len = 2'd0;
    i_msg = (128'd1 << 127) | 128'd1;
    start_frame();
    run(20, 5, -1, 135, lat, nd);
    e = imp_exp(9'b111, 9'b101, 9'b0, 3, 1'b0);
    e = e | (e >> 254);
    chk("stall_frame", o_frame, e);
    chk("stall_lat", FW'(lat), FW'(135));
    en = 1'b0;
    @(negedge sys_clk);
    chk("stall_done_hold", FW'(o_done), FW'(1));
    en = 1'b1;
    @(negedge sys_clk);
    chk("stall_done_clr", FW'(o_done), '0);

    i_msg = 128'd1 << 127;
    start_frame();
    run(-1, 0, -1, 50, lat, nd);
    rst = 1'b0;
    #1;
    chk("abort_busy", FW'(o_busy), '0);
    chk("abort_frame", o_frame, '0);
    chk("abort_len", FW'(o_frame_len), '0);
    @(negedge sys_clk);
    rst = 1'b1;
    run(-1, 0, -1, 200, lat, nd);
    chk("abort_ndone", FW'(nd), '0);
    chk("abort_frame_hold", o_frame, '0);

    poly[0] = 9'b001111001;
    poly[1] = 9'b001011011;
    i_constr_len = 2'd2;
    i_code_rate = 1'b0;
    start_frame();
    chk("k7_len", FW'(o_frame_len), FW'(268));
    run(-1, 0, -1, 150, lat, nd);
    e = imp_exp(9'b001111001, 9'b001011011, 9'b0, 7, 1'b0);
    chk("k7_frame", o_frame, e);
    chk("k7_lat", FW'(lat), FW'(134));
    chk("k7_ndone", FW'(nd), FW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
